alu_cmd_issuer: RTL

Command-buffering and issue stage that sits directly upstream of the 4-bit `alu`. It accepts `{op_code, A, B}` commands over a valid/ready handshake and holds them in a small FIFO. It drives one command at a time onto the ALU operand/opcode inputs, waits out the ALU's registered latency, and presents the returned 6-bit signed result downstream over a second valid/ready handshake. Results leave in command order, with the opcode as a tag.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_cmd_fifo.sv | 56 +++++
 rtl/alu_cmd_issuer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU and its command issuer.
package alu_pkg;
  localparam int DATA_W = 4;
  localparam int RES_W  = 6;

  typedef logic [1:0] alu_op_t;

  typedef struct packed {
    alu_op_t           op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} issue_state_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands. The caller only pushes when not full
// and only pops when not empty; head is visible combinationally.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  alu_cmd_t         wdata,
  input  logic             pop,
  output alu_cmd_t         rdata,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  alu_cmd_t         mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // DEPTH is a power of two, so pointer wrap is plain overflow.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = cnt_q;
endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, issues one at a time, waits out the ALU latency and
// hands the result downstream in command order with its opcode as a tag.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  input  alu_op_t                    in_op,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output alu_op_t                    alu_op,
  input  logic [RES_W-1:0]           alu_c,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RES_W-1:0]           out_c,
  output alu_op_t                    out_op,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int WC_W  = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT+1);

  issue_state_t     state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  alu_cmd_t         issue_q, issue_d;
  logic [RES_W-1:0] out_c_q, out_c_d;
  alu_op_t          out_op_q, out_op_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop;
  alu_cmd_t         head, wcmd;

  // Full blocks pushes outright, even if a pop lands on the same edge.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign wcmd     = '{op: in_op, a: in_a, b: in_b};

  alu_cmd_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wcmd),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    issue_d     = issue_q;
    out_c_d     = out_c_q;
    out_op_d    = out_op_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          issue_d = head;
          wcnt_d  = WC_W'(ALU_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          out_c_d     = alu_c;
          out_op_d    = issue_q.op;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          wcnt_d = wcnt_q - WC_W'(1);
        end
      end
      HOLD: begin
        // Release and next issue share one edge to keep the pipe full.
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (count != '0) begin
            pop     = 1'b1;
            issue_d = head;
            wcnt_d  = WC_W'(ALU_LAT);
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      issue_q     <= '0;
      out_c_q     <= '0;
      out_op_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      issue_q     <= issue_d;
      out_c_q     <= out_c_d;
      out_op_q    <= out_op_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign alu_a     = issue_q.a;
  assign alu_b     = issue_q.b;
  assign alu_op    = issue_q.op;
  assign out_c     = out_c_q;
  assign out_op    = out_op_q;
  assign out_valid = out_valid_q;
endmodule
